// File: rtl/mem_info_arb_pkg.sv
// mem_info_arb_pkg
//   Shared types and default sizes for the info-RAM arbiter.
//   - Default address/data/byteenable widths of the 256x32 info RAM.
//   - Arbiter ownership state encoding.
//   - Requester (owner) index type and a helper that maps an owner to its state.
package mem_info_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int BE_W_DEF   = DATA_W_DEF / 8;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // 0 = m0 (CPU data master), 1 = m1 (DMA/loader)
    typedef logic owner_t;

    function automatic arb_state_e own_state(input owner_t owner);
        return owner ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/mem_info_rr_grant.sv
// mem_info_rr_grant
//   Bounded-burst round-robin grant engine for two requesters.
//   The grant is combinational from the registered state and the current
//   requests; at most one requester is granted per cycle.
// Ports:
//   clk          sole clock
//   reset        asynchronous, active-high reset
//   req[1:0]     request per requester (read or write)
//   block        suppresses all grants and freezes the arbitration state
//   grant[1:0]   one-hot grant (all zero when nothing is accepted)
//   grant_vld    a grant is issued this cycle
//   grant_idx    index of the granted requester (valid with grant_vld)
//
// state | meaning
// IDLE  | no current owner; ties broken towards ~last_owner
// OWN0  | m0 owns the RAM, cnt = consecutive m0 accepts
// OWN1  | m1 owns the RAM, cnt = consecutive m1 accepts
module mem_info_rr_grant
    import mem_info_arb_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int TIE_FIRST = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       block,
    output logic [1:0] grant,
    output logic       grant_vld,
    output owner_t     grant_idx
);

    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    // last_owner resets to the opposite of TIE_FIRST so the first tie from
    // IDLE goes to TIE_FIRST.
    localparam owner_t LAST_RST = (TIE_FIRST != 0) ? 1'b0 : 1'b1;

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    owner_t           last_owner_q, last_owner_d;
    owner_t           cur_owner;
    owner_t           oth_owner;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_owner_q <= LAST_RST;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        grant_vld    = 1'b0;
        grant_idx    = 1'b0;
        cur_owner    = (state_q == OWN1);
        oth_owner    = ~cur_owner;

        // While blocked nothing is accepted and the arbitration history is
        // kept, so the burst resumes where it left off after the block.
        if (!block) begin
            case (state_q)
                IDLE: begin
                    if (req[0] && req[1]) begin
                        grant_vld = 1'b1;
                        grant_idx = ~last_owner_q;
                    end else if (req[0]) begin
                        grant_vld = 1'b1;
                        grant_idx = 1'b0;
                    end else if (req[1]) begin
                        grant_vld = 1'b1;
                        grant_idx = 1'b1;
                    end
                    if (grant_vld) begin
                        state_d = own_state(grant_idx);
                        cnt_d   = CNT_W'(1);
                    end
                end
                OWN0, OWN1: begin
                    // The owner keeps the RAM until its burst budget is spent,
                    // but only while the other side is actually waiting.
                    if (req[cur_owner] && ((cnt_q < BURST_LIM) || !req[oth_owner])) begin
                        grant_vld = 1'b1;
                        grant_idx = cur_owner;
                        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    end else if (req[oth_owner]) begin
                        grant_vld = 1'b1;
                        grant_idx = oth_owner;
                        state_d   = own_state(oth_owner);
                        cnt_d     = CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
            if (grant_vld) begin
                last_owner_d = grant_idx;
            end
        end
    end

    assign grant = {grant_vld & grant_idx, grant_vld & ~grant_idx};

endmodule

// File: rtl/mem_info_arbiter.sv
// mem_info_arbiter
//   Two-port arbiter in front of the single-port 256x32 info RAM
//   (byte-enabled, one-cycle read latency, clock-enable gated).
//   m0 is the CPU data master, m1 the DMA/loader. Transfers are accepted
//   combinationally (waitrequest low) and reads are pipelined so a transfer
//   can be accepted every cycle.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   reset_req                  RAM reset request; blocks grants, drops clken
//   m0_* / m1_*                Avalon-MM-style slave ports
//   mem_*                      single RAM port (mem_readdata valid one cycle
//                              after a read issue)
//   arb_err                    sticky: a master asserted read and write together
module mem_info_arbiter
    import mem_info_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BE_W      = BE_W_DEF,
    parameter int MAX_BURST = 4,
    parameter int TIE_FIRST = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_req,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,

    output logic              arb_err
);

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              grant_vld;
    owner_t            grant_idx;

    logic [ADDR_W-1:0] sel_address;
    logic [BE_W-1:0]   sel_byteenable;
    logic [DATA_W-1:0] sel_writedata;
    logic              sel_read;
    logic              sel_write;
    logic              rd_issue;

    logic              rd_vld_q, rd_vld_d;
    owner_t            rd_own_q, rd_own_d;
    logic              arb_err_q, arb_err_d;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    mem_info_rr_grant #(
        .MAX_BURST (MAX_BURST),
        .TIE_FIRST (TIE_FIRST)
    ) u_rr_grant (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .block     (reset_req),
        .grant     (grant),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    assign m0_waitrequest = req[0] & ~grant[0];
    assign m1_waitrequest = req[1] & ~grant[1];

    always_comb begin
        sel_address    = grant_idx ? m1_address    : m0_address;
        sel_byteenable = grant_idx ? m1_byteenable : m0_byteenable;
        sel_writedata  = grant_idx ? m1_writedata  : m0_writedata;
        sel_read       = grant_idx ? m1_read       : m0_read;
        sel_write      = grant_idx ? m1_write      : m0_write;
    end

    // Write wins when a master illegally asserts both; the read half is dropped.
    assign rd_issue = grant_vld & sel_read & ~sel_write;

    always_comb begin
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        if (grant_vld) begin
            mem_chipselect = 1'b1;
            mem_write      = sel_write;
            mem_address    = sel_address;
            mem_writedata  = sel_writedata;
            mem_byteenable = sel_write ? sel_byteenable : '1;
        end
    end

    assign mem_clken = ~reset_req;

    always_comb begin
        rd_vld_d  = rd_issue;
        rd_own_d  = rd_issue ? grant_idx : rd_own_q;
        arb_err_d = arb_err_q | (m0_read & m0_write) | (m1_read & m1_write);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld_q  <= 1'b0;
            rd_own_q  <= 1'b0;
            arb_err_q <= 1'b0;
        end else begin
            rd_vld_q  <= rd_vld_d;
            rd_own_q  <= rd_own_d;
            arb_err_q <= arb_err_d;
        end
    end

    // The RAM address was registered at the issue edge, so the returning word
    // is forwarded even if reset_req has since dropped the clock enable.
    assign m0_readdatavalid = rd_vld_q & ~rd_own_q;
    assign m1_readdatavalid = rd_vld_q &  rd_own_q;
    assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
    assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

    assign arb_err = arb_err_q;

endmodule

// File: tb/tb_mem_info_arbiter.sv
module tb_mem_info_arbiter;

    typedef struct {
        logic        r;
        logic        w;
        logic [7:0]  a;
        logic [3:0]  be;
        logic [31:0] d;
    } port_t;

    typedef struct {
        logic        rr;
        port_t       p0;
        port_t       p1;
        logic [1:0]  wt;   // {m1_waitrequest, m0_waitrequest}
        logic [1:0]  rv;   // {m1_readdatavalid, m0_readdatavalid}
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        ck;
        logic        cs;
        logic        wr;
        logic [7:0]  ma;
        logic [3:0]  mb;
        logic [31:0] md;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reset_req = 1'b0;
    logic [7:0]  m0_address = '0, m1_address = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [7:0]  mem_address;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = '0;
    logic        arb_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ram [256];

    always #5 clk = ~clk;

    mem_info_arbiter #(
        .ADDR_W(8), .DATA_W(32), .BE_W(4), .MAX_BURST(4), .TIE_FIRST(0)
    ) dut (
        .clk(clk), .reset(reset), .reset_req(reset_req),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata), .arb_err(arb_err)
    );

    // Behavioural 256x32 RAM: byte-enabled, clken-gated, registered read.
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = '0;
    end

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    function automatic port_t p_no();
        port_t p;
        p = '{r: 1'b0, w: 1'b0, a: 8'h00, be: 4'h0, d: 32'h0};
        return p;
    endfunction

    function automatic port_t p_rd(input logic [7:0] a);
        port_t p;
        p = '{r: 1'b1, w: 1'b0, a: a, be: 4'h0, d: 32'h0};
        return p;
    endfunction

    function automatic port_t p_wr(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
        port_t p;
        p = '{r: 1'b0, w: 1'b1, a: a, be: be, d: d};
        return p;
    endfunction

    function automatic port_t p_rw(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
        port_t p;
        p = '{r: 1'b1, w: 1'b1, a: a, be: be, d: d};
        return p;
    endfunction

    function automatic vec_t mk(input logic rr, input port_t p0, input port_t p1,
                                input logic [1:0] wt, input logic [1:0] rv,
                                input logic [31:0] rd0, input logic [31:0] rd1,
                                input logic ck, input logic cs, input logic wr,
                                input logic [7:0] ma, input logic [3:0] mb,
                                input logic [31:0] md, input logic err);
        vec_t v;
        v.rr = rr; v.p0 = p0; v.p1 = p1; v.wt = wt; v.rv = rv;
        v.rd0 = rd0; v.rd1 = rd1; v.ck = ck; v.cs = cs; v.wr = wr;
        v.ma = ma; v.mb = mb; v.md = md; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rr, input port_t p0, input port_t p1);
        reset_req     = rr;
        m0_read       = p0.r;  m0_write      = p0.w;  m0_address = p0.a;
        m0_byteenable = p0.be; m0_writedata  = p0.d;
        m1_read       = p1.r;  m1_write      = p1.w;  m1_address = p1.a;
        m1_byteenable = p1.be; m1_writedata  = p1.d;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        chk({tag, " wait"},   {62'd0, m1_waitrequest, m0_waitrequest}, {62'd0, v.wt});
        chk({tag, " rdvalid"}, {62'd0, m1_readdatavalid, m0_readdatavalid}, {62'd0, v.rv});
        chk({tag, " rdata0"}, {32'd0, m0_readdata}, {32'd0, v.rd0});
        chk({tag, " rdata1"}, {32'd0, m1_readdata}, {32'd0, v.rd1});
        chk({tag, " memctl"}, {56'd0, mem_clken, mem_chipselect, mem_write, 1'b0, mem_byteenable},
                              {56'd0, v.ck, v.cs, v.wr, 1'b0, v.mb});
        chk({tag, " memaddr"}, {56'd0, mem_address}, {56'd0, v.ma});
        chk({tag, " memwdata"}, {32'd0, mem_writedata}, {32'd0, v.md});
        chk({tag, " arb_err"}, {63'd0, arb_err}, {63'd0, v.err});
    endtask

    vec_t vecs[$];

    initial begin
        int own_prev;
        int own_now;

        // Table: {reset_req, m0, m1} -> {wait, rdvalid, rdata0, rdata1, clken, cs, write, addr, be, wdata, err}
        vecs.push_back(mk(0, p_no(), p_no(), 2'b00, 2'b00, 32'h0, 32'h0, 1, 0, 0, 8'h00, 4'h0, 32'h0, 0));
        vecs.push_back(mk(0, p_wr(8'h10, 4'hF, 32'hDEADBEEF), p_no(), 2'b00, 2'b00, 32'h0, 32'h0, 1, 1, 1, 8'h10, 4'hF, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, p_rd(8'h10), p_no(), 2'b00, 2'b00, 32'h0, 32'h0, 1, 1, 0, 8'h10, 4'hF, 32'h0, 0));
        vecs.push_back(mk(0, p_no(), p_wr(8'h10, 4'b0010, 32'h0000AB00), 2'b00, 2'b01, 32'hDEADBEEF, 32'h0, 1, 1, 1, 8'h10, 4'h2, 32'h0000AB00, 0));
        vecs.push_back(mk(0, p_rd(8'h10), p_no(), 2'b00, 2'b00, 32'h0, 32'h0, 1, 1, 0, 8'h10, 4'hF, 32'h0, 0));
        vecs.push_back(mk(0, p_no(), p_no(), 2'b00, 2'b01, 32'hDEADABEF, 32'h0, 1, 0, 0, 8'h00, 4'h0, 32'h0, 0));
        // read & write together: write performed, error flagged from next cycle
        vecs.push_back(mk(0, p_rw(8'h20, 4'hF, 32'h12345678), p_no(), 2'b00, 2'b00, 32'h0, 32'h0, 1, 1, 1, 8'h20, 4'hF, 32'h12345678, 0));
        vecs.push_back(mk(0, p_rd(8'h20), p_no(), 2'b00, 2'b00, 32'h0, 32'h0, 1, 1, 0, 8'h20, 4'hF, 32'h0, 1));
        vecs.push_back(mk(0, p_no(), p_no(), 2'b00, 2'b01, 32'h12345678, 32'h0, 1, 0, 0, 8'h00, 4'h0, 32'h0, 1));
        // reset_req blocks m0 for 3 cycles, grant on release
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, p_rd(8'h10), p_no(), 2'b01, 2'b00, 32'h0, 32'h0, 0, 0, 0, 8'h00, 4'h0, 32'h0, 1));
        vecs.push_back(mk(0, p_rd(8'h10), p_no(), 2'b00, 2'b00, 32'h0, 32'h0, 1, 1, 0, 8'h10, 4'hF, 32'h0, 1));
        // reset_req right after a read grant: read still returns
        vecs.push_back(mk(1, p_no(), p_no(), 2'b00, 2'b01, 32'hDEADABEF, 32'h0, 0, 0, 0, 8'h00, 4'h0, 32'h0, 1));
        vecs.push_back(mk(0, p_no(), p_no(), 2'b00, 2'b00, 32'h0, 32'h0, 1, 0, 0, 8'h00, 4'h0, 32'h0, 1));
        // lone requester keeps the RAM past MAX_BURST
        vecs.push_back(mk(0, p_rd(8'h10), p_no(), 2'b00, 2'b00, 32'h0, 32'h0, 1, 1, 0, 8'h10, 4'hF, 32'h0, 1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, p_rd(8'h10), p_no(), 2'b00, 2'b01, 32'hDEADABEF, 32'h0, 1, 1, 0, 8'h10, 4'hF, 32'h0, 1));
        vecs.push_back(mk(0, p_no(), p_no(), 2'b00, 2'b01, 32'hDEADABEF, 32'h0, 1, 0, 0, 8'h00, 4'h0, 32'h0, 1));
        // m1 read routed to m1 only
        vecs.push_back(mk(0, p_no(), p_rd(8'h20), 2'b00, 2'b00, 32'h0, 32'h0, 1, 1, 0, 8'h20, 4'hF, 32'h0, 1));
        vecs.push_back(mk(0, p_no(), p_no(), 2'b00, 2'b10, 32'h0, 32'h12345678, 1, 0, 0, 8'h00, 4'h0, 32'h0, 1));

        // Reset state, with both masters idle
        #3;
        chk("reset wait", {62'd0, m1_waitrequest, m0_waitrequest}, 64'd0);
        chk("reset rdvalid", {62'd0, m1_readdatavalid, m0_readdatavalid}, 64'd0);
        chk("reset rdata", {m1_readdata, m0_readdata}, 64'd0);
        chk("reset cs/err", {62'd0, mem_chipselect, arb_err}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rr, vecs[i].p0, vecs[i].p1);
            #4;
            check_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Streaming reads from both masters after a fresh reset.
        @(negedge clk);
        drive(0, p_no(), p_no());
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        own_prev = -1;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            drive(0, p_rd(8'h10), p_rd(8'h20));
            #4;
            own_now = (k / 4) % 2;
            chk($sformatf("stream%0d wait", k), {62'd0, m1_waitrequest, m0_waitrequest},
                (own_now == 0) ? 64'd2 : 64'd1);
            chk($sformatf("stream%0d memaddr", k), {56'd0, mem_address},
                (own_now == 0) ? 64'h10 : 64'h20);
            chk($sformatf("stream%0d rdvalid", k), {62'd0, m1_readdatavalid, m0_readdatavalid},
                (own_prev == 0) ? 64'd1 : (own_prev == 1) ? 64'd2 : 64'd0);
            chk($sformatf("stream%0d rdata", k), {m1_readdata, m0_readdata},
                (own_prev == 0) ? 64'h00000000_DEADABEF :
                (own_prev == 1) ? 64'h12345678_00000000 : 64'd0);
            own_prev = own_now;
        end

        // Async reset in the cycle after a read grant.
        @(negedge clk);
        drive(0, p_no(), p_no());
        @(negedge clk);
        drive(0, p_rw(8'h30, 4'hF, 32'h0), p_no());
        @(negedge clk);
        drive(0, p_rd(8'h10), p_no());
        #4;
        chk("pre-rst wait", {63'd0, m0_waitrequest}, 64'd0);
        chk("pre-rst arb_err", {63'd0, arb_err}, 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(0, p_no(), p_no());
        #2;
        chk("rst rdvalid", {62'd0, m1_readdatavalid, m0_readdatavalid}, 64'd0);
        chk("rst arb_err", {63'd0, arb_err}, 64'd0);
        chk("rst cs", {63'd0, mem_chipselect}, 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #4;
            chk($sformatf("rst hold%0d rdvalid", i), {62'd0, m1_readdatavalid, m0_readdatavalid}, 64'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        #4;
        chk("post-rst rdvalid", {62'd0, m1_readdatavalid, m0_readdatavalid}, 64'd0);
        @(negedge clk);
        drive(0, p_rd(8'h10), p_rd(8'h20));
        #4;
        chk("post-rst tie wait", {62'd0, m1_waitrequest, m0_waitrequest}, 64'd2);
        chk("post-rst arb_err", {63'd0, arb_err}, 64'd0);
        @(negedge clk);
        drive(0, p_no(), p_no());
        #4;
        chk("post-rst rdata0", {31'd0, m0_readdatavalid, m0_readdata}, {31'd0, 1'b1, 32'hDEADABEF});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_info_arbiter.md
Name: mem_info_arbiter

Overview:
- Two-requester arbiter in front of the 256x32 single-port on-chip info RAM (byte-enabled, 1-cycle read latency, clock-enable gated).
- Presents two Avalon-MM-style slave ports (m0 = CPU data master, m1 = DMA/loader) and drives the single RAM port.
- Fairness: a bounded-burst round-robin. Reads are pipelined so one transfer can be accepted every cycle.

Parameters:
- ADDR_W, 8, RAM word address width.
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).
- MAX_BURST, 4, max consecutive accepts for one owner while the other requester waits (1..15).
- TIE_FIRST, 0, requester granted from IDLE after reset when both request.

Ports:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- reset_req  in  1  RAM reset request; blocks grants and gates RAM clock enable
- mX_address  in  ADDR_W  requester X word address (X = 0,1)
- mX_read  in  1  read request
- mX_write  in  1  write request
- mX_byteenable  in  BE_W  write byte lanes
- mX_writedata  in  DATA_W  write data
- mX_waitrequest  out  1  high = transfer not accepted this cycle
- mX_readdata  out  DATA_W  read data
- mX_readdatavalid  out  1  read data valid strobe
- mem_address  out  ADDR_W  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_byteenable  out  BE_W  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_clken  out  1  to RAM clocken
- mem_readdata  in  DATA_W  from RAM, valid the cycle after a read issue
- arb_err  out  1  sticky protocol-violation flag

Behaviour:
- Request definition: reqX = mX_read | mX_write. Accepting a request = the grant.
- Grant logic is combinational from registered state and current requests. At most one grant per cycle.
- mX_waitrequest = reqX & ~grantX. It is 0 when there is no request, so it is 0 in reset.
- States:
  - IDLE, OWN0, OWN1, plus a burst counter cnt (4 bits) and last_owner.
  - Reset values: state = IDLE, cnt = 0, last_owner = ~TIE_FIRST.
- Grant rules (no grant while reset_req = 1):
  - IDLE, single requester: grant it.
  - IDLE, both request: grant ~last_owner.
  - OWNx with reqx, and (cnt < MAX_BURST or ~req of the other): grant x, cnt++ (saturating at 15).
  - Otherwise the other requester is requesting: grant it, state = OWN(other), cnt = 1.
  - No request at all: state = IDLE, cnt = 0.
  - On every grant, last_owner <= granted index.
- RAM drive, on the grant cycle:
  - mem_chipselect = 1.
  - mem_address, mem_writedata and mem_byteenable are muxed from the granted requester.
  - mem_write = granted mX_write.
  - On reads, mem_byteenable is forced to all-ones.
  - With no grant: chipselect = 0, write = 0, other mem outputs = 0.
- mem_clken = ~reset_req.
- Read pipeline:
  - A read granted in cycle N sets rd_vld_q = 1 and rd_own_q = X at edge N+1.
  - In cycle N+1: mX_readdatavalid = rd_vld_q & (rd_own_q == X), and mX_readdata = mem_readdata.
  - The non-owning port's readdata is 0.
  - Back-to-back reads (either owner) are supported, one per cycle.
  - Reset values: rd_vld_q = 0, all readdatavalid = 0, all readdata = 0.
- Read-after-write to the same address in consecutive cycles returns the new data. The RAM read-during-write mode is DONT_CARE, but write and read are in different cycles here.
- reset_req asserted in the cycle after a read grant: the read still completes (the RAM address is already registered). readdatavalid pulses normally.
- Protocol violation: mX_read & mX_write together. Write wins, the read is dropped, and arb_err is set (sticky until reset).
- Asynchronous reset mid-transfer: all state and outputs clear immediately. Any pending readdatavalid is lost.

Decomposition:
- Package mem_info_arb_pkg:
  - ADDR_W/DATA_W/BE_W defaults.
  - State enum {IDLE, OWN0, OWN1}.
  - Owner index type.
- One sub-module: mem_info_rr_grant. Combinational grant and next-state logic plus the state/cnt/last_owner registers, with inputs req[1:0] and block.
- The top level holds the datapath muxes, the read pipeline register and arb_err.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to addr 0x10 with be = 4'hF, then reads 0x10. Required: m0_waitrequest = 0 both cycles, and m0_readdatavalid one cycle after the read with m0_readdata = 0xDEADBEEF.
- m1 byte write: be = 4'b0010, data 0x0000AB00 to addr 0x10, then m0 reads 0x10. Required: 0xDEADABEF.
- Both masters stream continuous reads, MAX_BURST = 4. Required grant pattern from IDLE with TIE_FIRST = 0: m0 ×4, m1 ×4, m0 ×4…; the waiting port's waitrequest = 1 throughout; readdatavalid routed only to the correct port.
- reset_req = 1 for 3 cycles while m0 requests. Required: mem_clken = 0, m0_waitrequest = 1 for 3 cycles, grant on the first cycle after release.
- m0 asserts read & write together to addr 0x20. Required: write performed, arb_err = 1 and remains 1 until reset; no readdatavalid.
- Async reset asserted in the cycle after a read grant. Required: readdatavalid never pulses, state returns to IDLE, arb_err = 0.
